uart_port: RTL

- Byte-level UART endpoint directly downstream of the memory controller's UART-side byte interface.
- Accepts command and data bytes from the controller over a 4-phase we/wack handshake, queues them in a TX FIFO and serialises them 8N1 on Tx.
- Deserialises Rx into an RX FIFO and hands bytes back over a 4-phase re/rack handshake.
- Publishes FIFO status as ra (byte available) and wa (space available).

---
 rtl/uart_port.sv | 276 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_port.sv
// uart_port: byte-level 8N1 UART endpoint.
//   clk, rst (async, active-low)
//   din/we/wack  : 4-phase write handshake, each accepted byte is queued in the TX FIFO
//   dout/re/rack : 4-phase read handshake, each accepted read pops one byte from the RX FIFO
//   wa / ra      : TX FIFO not full / RX FIFO not empty
//   Tx / Rx      : serial line (Rx is asynchronous and is double-synchronised)
//   rx_ferr      : sticky flag, a stop bit was sampled low
//   rx_ovf       : sticky flag, a complete frame was dropped because the RX FIFO was full
module uart_port #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_ADDR_L  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic       we,
  input  logic       re,
  output logic       wack,
  output logic       rack,
  output logic       wa,
  output logic       ra,
  input  logic       Rx,
  output logic       Tx,
  output logic       rx_ferr,
  output logic       rx_ovf
);

  localparam int unsigned DEPTH = 1 << FIFO_ADDR_L;
  localparam int unsigned PW    = FIFO_ADDR_L + 1;
  localparam int unsigned CW    = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  // RX_BREAK holds off start detection after a framing error until the line returns high.
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;

  // ---------------- TX FIFO and write handshake ----------------
  logic [7:0]    tx_mem [DEPTH];
  logic [PW-1:0] tx_wp, tx_rp;
  logic          tx_full, tx_empty, tx_push, tx_pop;

  assign tx_empty = (tx_wp == tx_rp);
  assign tx_full  = (tx_wp[FIFO_ADDR_L-1:0] == tx_rp[FIFO_ADDR_L-1:0]) &&
                    (tx_wp[FIFO_ADDR_L] != tx_rp[FIFO_ADDR_L]);
  assign tx_push  = we && !wack && !tx_full;
  assign wa       = !tx_full;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp[FIFO_ADDR_L-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_wp <= '0;
      wack  <= 1'b0;
    end else if (tx_push) begin
      tx_wp <= tx_wp + PW'(1);
      wack  <= 1'b1;
    end else if (!we) begin
      wack  <= 1'b0;
    end
  end

  // ---------------- TX FSM ----------------
  tx_state_t     tx_state, tx_state_n;
  logic [CW-1:0] tx_cnt, tx_cnt_n;
  logic [2:0]    tx_bit, tx_bit_n;
  logic [7:0]    tx_shift, tx_shift_n;
  logic          tx_n, tx_last;

  assign tx_last = (tx_cnt == BIT_END);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_rp    <= '0;
      Tx       <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      Tx       <= tx_n;
      if (tx_pop) tx_rp <= tx_rp + PW'(1);
    end
  end

  // Tx is registered from the next-state line level so it never glitches.
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    tx_n       = 1'b1;
    tx_pop     = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_n = tx_mem[tx_rp[FIFO_ADDR_L-1:0]];
          tx_cnt_n   = '0;
          tx_state_n = TX_START;
          tx_n       = 1'b0;
        end
      end
      TX_START: begin
        tx_n = 1'b0;
        if (tx_last) begin
          tx_cnt_n   = '0;
          tx_bit_n   = '0;
          tx_state_n = TX_DATA;
          tx_n       = tx_shift[0];
        end else begin
          tx_cnt_n = tx_cnt + CW'(1);
        end
      end
      TX_DATA: begin
        tx_n = tx_shift[0];
        if (tx_last) begin
          tx_cnt_n = '0;
          if (tx_bit == 3'd7) begin
            tx_state_n = TX_STOP;
            tx_n       = 1'b1;
          end else begin
            tx_bit_n   = tx_bit + 3'd1;
            tx_shift_n = {1'b0, tx_shift[7:1]};
            tx_n       = tx_shift[1];
          end
        end else begin
          tx_cnt_n = tx_cnt + CW'(1);
        end
      end
      TX_STOP: begin
        tx_n = 1'b1;
        if (tx_last) begin
          tx_cnt_n = '0;
          // Chain straight into the next start bit when more data is queued.
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_shift_n = tx_mem[tx_rp[FIFO_ADDR_L-1:0]];
            tx_state_n = TX_START;
            tx_n       = 1'b0;
          end else begin
            tx_state_n = TX_IDLE;
          end
        end else begin
          tx_cnt_n = tx_cnt + CW'(1);
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  // ---------------- RX synchroniser and FSM ----------------
  logic          rx_s1, rx_s2;
  rx_state_t     rx_state, rx_state_n;
  logic [CW-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]    rx_bit, rx_bit_n;
  logic [7:0]    rx_shift, rx_shift_n;
  logic          rx_push, ferr_set, ovf_set, rx_last;
  logic [7:0]    rx_mem [DEPTH];
  logic [PW-1:0] rx_wp, rx_rp;
  logic          rx_full, rx_empty, rx_pop;

  assign rx_empty = (rx_wp == rx_rp);
  assign rx_full  = (rx_wp[FIFO_ADDR_L-1:0] == rx_rp[FIFO_ADDR_L-1:0]) &&
                    (rx_wp[FIFO_ADDR_L] != rx_rp[FIFO_ADDR_L]);
  assign rx_pop   = re && !rack && !rx_empty;
  assign ra       = !rx_empty;
  assign rx_last  = (rx_cnt == BIT_END);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_wp    <= '0;
      rx_ferr  <= 1'b0;
      rx_ovf   <= 1'b0;
    end else begin
      rx_s1    <= Rx;
      rx_s2    <= rx_s1;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
      if (rx_push)  rx_wp   <= rx_wp + PW'(1);
      if (ferr_set) rx_ferr <= 1'b1;
      if (ovf_set)  rx_ovf  <= 1'b1;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    rx_push    = 1'b0;
    ferr_set   = 1'b0;
    ovf_set    = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (!rx_s2) begin
          rx_cnt_n   = '0;
          rx_state_n = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt == HALF_END) begin
          rx_cnt_n   = '0;
          rx_bit_n   = '0;
          rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_n = rx_cnt + CW'(1);
        end
      end
      RX_DATA: begin
        if (rx_last) begin
          rx_cnt_n   = '0;
          rx_shift_n = {rx_s2, rx_shift[7:1]};
          if (rx_bit == 3'd7) rx_state_n = RX_STOP;
          else                rx_bit_n   = rx_bit + 3'd1;
        end else begin
          rx_cnt_n = rx_cnt + CW'(1);
        end
      end
      RX_STOP: begin
        if (rx_last) begin
          rx_cnt_n = '0;
          if (rx_s2) begin
            if (rx_full) ovf_set = 1'b1;
            else         rx_push = 1'b1;
            rx_state_n = RX_IDLE;
          end else begin
            ferr_set   = 1'b1;
            rx_state_n = RX_BREAK;
          end
        end else begin
          rx_cnt_n = rx_cnt + CW'(1);
        end
      end
      RX_BREAK: begin
        if (rx_s2) rx_state_n = RX_IDLE;
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp[FIFO_ADDR_L-1:0]] <= rx_shift;
  end

  // ---------------- Read handshake ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_rp <= '0;
      rack  <= 1'b0;
      dout  <= '0;
    end else if (rx_pop) begin
      dout  <= rx_mem[rx_rp[FIFO_ADDR_L-1:0]];
      rx_rp <= rx_rp + PW'(1);
      rack  <= 1'b1;
    end else if (!re) begin
      rack  <= 1'b0;
    end
  end

endmodule
